// File: rtl/md_seq.sv
// Issue sequencer for the E-stage multiply/divide unit. It tracks how long the unit is occupied,
// stalls HI/LO-dependent instructions while the unit runs, and counts the cycles spent stalled.
module md_seq #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              e_valid,
    input  logic [3:0]        e_op,
    output logic              md_start,
    output logic              md_mt,
    output logic [2:0]        md_op,
    output logic              mf_sel,
    output logic              busy,
    output logic              stall,
    output logic [PERF_W-1:0] stall_cycles,
    output logic              dbg_run
);

    // Handshake: an op is accepted when it is presented (e_valid) in IDLE with req low.
    // While stall is high the pipe holds the op and re-presents it on the following cycles.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       hd, ar, mt;

    assign hd = e_valid && (e_op >= 4'd1) && (e_op <= 4'd8);
    assign ar = e_valid && (e_op >= 4'd1) && (e_op <= 4'd4);
    assign mt = e_valid && ((e_op == 4'd5) || (e_op == 4'd6));

    assign dbg_run = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        md_start  = 1'b0;
        md_mt     = 1'b0;
        md_op     = 3'd7;
        mf_sel    = 1'b0;
        busy      = 1'b0;
        stall     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    // HI/LO are final once the unit is idle, so reads never stall here.
                    mf_sel = e_valid && (e_op == 4'd8);
                    if (ar && !req) begin
                        md_start  = 1'b1;
                        md_op     = e_op[2:0] - 3'd1;
                        state_nxt = RUN;
                        cnt_nxt   = (e_op <= 4'd2) ? MULT_CNT : DIV_CNT;
                    end else if (mt && !req) begin
                        md_mt = 1'b1;
                        md_op = e_op[2:0] - 3'd1;
                    end
                end
                RUN: begin
                    // An issued op is committed; req does not abort it.
                    busy    = 1'b1;
                    stall   = hd;
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {PERF_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
